// File: rtl/roba_mult_arbiter_if.sv
// Handshake bundle between NREQ client datapaths and the shared ROBA
// multiplier arbiter. The master side is the clients plus the result
// consumer, and the slave side is the arbiter.
interface roba_mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ <= 2) ? 1 : $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_x;
  logic [16*NREQ-1:0] req_y;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_p;
  logic [IDW-1:0]     res_id;
  logic               busy;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_p, res_id, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_p, res_id, busy
  );
endinterface

// File: rtl/roba_mult_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ROBA 16x16
// approximate multiplier among NREQ requesters. Each transaction runs
// IDLE (grant, capture operands) -> MUL (core settles, capture product)
// -> HOLD (present result until the consumer accepts it).
module roba_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  roba_mult_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [15:0]    x_reg;
  logic [15:0]    y_reg;
  logic [31:0]    p_reg;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           grant_valid;
  logic           load_op;
  logic           load_p;
  logic [31:0]    roba_p;

  logic [15:0]    x_arr [NREQ];
  logic [15:0]    y_arr [NREQ];

  // Split the flat operand buses per requester and build the one-hot ready.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign x_arr[gi]         = bus.req_x[16*gi +: 16];
      assign y_arr[gi]         = bus.req_y[16*gi +: 16];
      assign bus.req_ready[gi] = grant_valid && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Rounding of an operand to its nearest power of two, returned as the
  // exponent. Values at or above 1.5 * 2^k round up to 2^(k+1); a zero
  // operand is handled separately by the caller.
  function automatic logic [4:0] round_shift(input logic [15:0] v);
    logic [3:0] k;
    logic       up;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) k = 4'(i);
    end
    up = (k != 4'd0) ? v[k - 4'd1] : 1'b0;
    return {1'b0, k} + {4'b0, up};
  endfunction

  // Search for the first valid requester starting at the priority pointer.
  always_comb begin
    logic [IDW:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grants are only offered from IDLE and never while reset is asserted.
  assign grant_valid = (state_reg == IDLE) && grant_found && !rst;
  assign ptr_next    = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);

  // ROBA core: Ar*B + Br*A - Ar*Br computed with shifts, wrapping mod 2^32.
  always_comb begin
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [31:0] term_a;
    logic [31:0] term_b;
    logic [31:0] term_ab;
    sa      = round_shift(x_reg);
    sb      = round_shift(y_reg);
    term_a  = {16'b0, y_reg} << sa;
    term_b  = {16'b0, x_reg} << sb;
    term_ab = 32'd1 << ({1'b0, sa} + {1'b0, sb});
    roba_p  = '0;
    if (x_reg != 16'd0 && y_reg != 16'd0) roba_p = term_a + term_b - term_ab;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state and datapath load enables.
  always_comb begin
    state_next = state_reg;
    load_op    = 1'b0;
    load_p     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          load_op    = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        load_p     = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand, owner, pointer and product registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg   <= '0;
      y_reg   <= '0;
      p_reg   <= '0;
      id_reg  <= '0;
      ptr_reg <= '0;
    end else begin
      if (load_op) begin
        x_reg   <= x_arr[grant_idx];
        y_reg   <= y_arr[grant_idx];
        id_reg  <= grant_idx;
        ptr_reg <= ptr_next;
      end
      if (load_p) p_reg <= roba_p;
    end
  end

  assign bus.res_valid = (state_reg == HOLD);
  assign bus.res_p     = p_reg;
  assign bus.res_id    = id_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_roba_mult_arbiter.sv
// Directed testbench for roba_mult_arbiter with four requesters.
module tb_roba_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;
  int   exp_ptr;

  roba_mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  roba_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: nearest power of two, ties at 1.5*2^k rounding up.
  function automatic longint round_p2(input longint v);
    longint p;
    if (v == 0) return 0;
    p = 1;
    while (p * 2 <= v) p = p * 2;
    if (p >= 2 && (v - p) >= p / 2) return 2 * p;
    return p;
  endfunction

  function automatic logic [31:0] roba_model(input logic [15:0] a, input logic [15:0] b);
    longint la, lb, ar, br, r;
    la = longint'(a);
    lb = longint'(b);
    ar = round_p2(la);
    br = round_p2(lb);
    r  = ar * lb + br * la - ar * br;
    return r[31:0];
  endfunction

  // Stimulus helper: one requester alone sends one pair and the result is
  // collected with res_ready=1. lat counts negedges from acceptance to res_valid.
  task automatic run_one(input int id, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] p, output logic [IDW-1:0] rid,
                         output int lat, output bit ok);
    int n;
    ok  = 1'b0;
    lat = -1;
    p   = '0;
    rid = '0;
    @(negedge clk);
    bus.req_valid         = '0;
    bus.req_valid[id]     = 1'b1;
    bus.req_x[16*id +: 16] = x;
    bus.req_y[16*id +: 16] = y;
    bus.res_ready         = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready[id] !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.req_ready[id] !== 1'b1) begin
      bus.req_valid = '0;
      return;
    end
    @(posedge clk);
    exp_ptr = (id + 1) % NREQ;
    #1;
    bus.req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.res_valid !== 1'b1 && n < 10);
    if (bus.res_valid === 1'b1) begin
      ok  = 1'b1;
      p   = bus.res_p;
      rid = bus.res_id;
      lat = n;
    end
  endtask

  task automatic test_reset();
    logic [31:0]    p;
    logic [IDW-1:0] rid;
    int             n;
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[16*i +: 16] = 16'h0002;
      bus.req_y[16*i +: 16] = 16'h0003;
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0 || bus.res_p !== 32'd0 ||
          bus.res_id !== 2'd0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b valid=%b p=%h id=%0d busy=%b, required 0000 0 0 0 0",
                 bus.req_ready, bus.res_valid, bus.res_p, bus.res_id, bus.busy);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: req_ready=%b, required 0001", bus.req_ready);
    end
    @(posedge clk);
    exp_ptr = 1;
    #1;
    bus.req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.res_valid !== 1'b1 && n < 10);
    p   = bus.res_p;
    rid = bus.res_id;
    checks++;
    if (bus.res_valid !== 1'b1 || rid !== 2'd0 || p !== 32'd6) begin
      errors++;
      $display("FAIL reset_first_result: valid=%b id=%0d p=%h, required 1 0 00000006",
               bus.res_valid, rid, p);
    end
    $display("txn reset: first grant id=%0d p=%h", rid, p);
  endtask

  task automatic test_single();
    logic [31:0]    p;
    logic [IDW-1:0] rid;
    int             lat;
    bit             ok;
    run_one(2, 16'h0100, 16'h0040, p, rid, lat, ok);
    checks++;
    if (!ok || lat != 2) begin
      errors++;
      $display("FAIL single_latency: ok=%0d latency=%0d, required 1 2", ok, lat);
    end
    checks++;
    if (p !== 32'h0000_4000 || rid !== 2'd2) begin
      errors++;
      $display("FAIL single_result: p=%h id=%0d, required 00004000 2", p, rid);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_drop: res_valid=%b at T+3, required 0", bus.res_valid);
    end
    $display("txn single: id=%0d p=%h latency=%0d", rid, p, lat);
  endtask

  task automatic test_arith();
    logic [15:0] xv [5] = '{16'h0000, 16'h0003, 16'hFFFF, 16'h0005, 16'h0001};
    logic [15:0] yv [5] = '{16'h1234, 16'h0003, 16'hFFFF, 16'h0006, 16'h8000};
    logic [31:0] ev [5] = '{32'h0000_0000, 32'h0000_0008, 32'hFFFE_0000, 32'h0000_0020, 32'h0000_8000};
    logic [31:0]    p;
    logic [IDW-1:0] rid;
    int             lat;
    bit             ok;
    int             rand_err;
    logic [15:0]    rx, ry;
    for (int i = 0; i < 5; i++) begin
      run_one(i % NREQ, xv[i], yv[i], p, rid, lat, ok);
      checks++;
      if (!ok || p !== ev[i]) begin
        errors++;
        $display("FAIL arith_directed[%0d]: ok=%0d p=%h, required %h", i, ok, p, ev[i]);
      end
      $display("txn arith: x=%h y=%h p=%h", xv[i], yv[i], p);
    end
    rand_err = 0;
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_one(i % NREQ, rx, ry, p, rid, lat, ok);
      checks++;
      if (!ok || p !== roba_model(rx, ry) || rid !== IDW'(i % NREQ)) begin
        errors++;
        rand_err++;
        $display("FAIL arith_random[%0d]: x=%h y=%h p=%h id=%0d, required %h id=%0d",
                 i, rx, ry, p, rid, roba_model(rx, ry), i % NREQ);
      end
    end
    $display("txn random: 1000 pairs, %0d wrong", rand_err);
  endtask

  task automatic test_round_robin();
    int start;
    int got;
    int last_cyc;
    int n;
    int exp_id;
    start = exp_ptr;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[16*i +: 16] = 16'(i + 1);
      bus.req_y[16*i +: 16] = 16'h0100;
    end
    bus.res_ready = 1'b1;
    bus.req_valid = '1;
    got      = 0;
    last_cyc = 0;
    n        = 0;
    while (got < 8 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.res_valid === 1'b1) begin
        exp_id = (start + got) % NREQ;
        checks++;
        if (bus.res_id !== IDW'(exp_id) || bus.res_p !== 32'((exp_id + 1) * 256)) begin
          errors++;
          $display("FAIL rr_order[%0d]: id=%0d p=%h, required %0d %h",
                   got, bus.res_id, bus.res_p, exp_id, 32'((exp_id + 1) * 256));
        end
        if (got > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: gap=%0d cycles, required 3", got, cyc - last_cyc);
          end
        end
        $display("txn rr: id=%0d p=%h cycle=%0d", bus.res_id, bus.res_p, cyc);
        last_cyc = cyc;
        got++;
      end
    end
    bus.req_valid = '0;
    exp_ptr = (start + got) % NREQ;
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL rr_count: results=%0d, required 8", got);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]    p0;
    logic [IDW-1:0] id0;
    int             n;
    int             nxt;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[16*i +: 16] = 16'h0010 + 16'(i);
      bus.req_y[16*i +: 16] = 16'h0020;
    end
    bus.res_ready = 1'b0;
    bus.req_valid = '1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.res_valid !== 1'b1 && n < 10);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== IDW'(exp_ptr)) begin
      errors++;
      $display("FAIL bp_first: valid=%b id=%0d, required 1 %0d", bus.res_valid, bus.res_id, exp_ptr);
    end
    p0  = bus.res_p;
    id0 = bus.res_id;
    nxt = (exp_ptr + 1) % NREQ;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_p !== p0 || bus.res_id !== id0 ||
          bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b p=%h id=%0d ready=%b busy=%b, required 1 %h %0d 0000 1",
                 c, bus.res_valid, bus.res_p, bus.res_id, bus.req_ready, bus.busy, p0, id0);
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 4'(1 << nxt) || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: req_ready=%b valid=%b, required %b 0",
               bus.req_ready, bus.res_valid, 4'(1 << nxt));
    end
    bus.req_valid = '0;
    exp_ptr = nxt;
    $display("txn backpressure: id=%0d p=%h held 5 cycles", id0, p0);
  endtask

  task automatic test_mid_reset();
    int n;
    int seen;
    @(negedge clk);
    bus.req_x[16*3 +: 16] = 16'h0007;
    bus.req_y[16*3 +: 16] = 16'h0009;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    n = 0;
    while (bus.req_ready[3] !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_mul: busy=%b valid=%b, required 1 0", bus.busy, bus.res_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result: res_valid cycles=%0d busy=%b, required 0 0", seen, bus.busy);
    end
    bus.req_valid = '1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr: req_ready=%b, required 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    exp_ptr = 0;
    $display("txn midreset: transaction dropped, next grant at 0");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    cyc           = 0;
    exp_ptr       = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
